// File: rtl/scandoubler_px.sv
// Scan doubler: splits composite sync by pulse length, ping-pong buffers each input
// line and replays it at double rate with optional scanline darkening.
module scandoubler_px #(
  parameter int PW         = 1,
  parameter int LINE_LEN   = 414,
  parameter int BUF_DEPTH  = 512,
  parameter int VS_THRESH  = 90,
  parameter int H_DE_START = 32,
  parameter int H_DE_END   = 364,
  parameter int V_DE_START = 16,
  parameter int V_DE_END   = 296,
  parameter int HS_END     = 384
) (
  input  logic          clkvga,
  input  logic          rst,
  input  logic          ce_2pix,
  input  logic [1:0]    scan_mode,
  input  logic          csync,
  input  logic [PW-1:0] v_in,
  output logic          hs_out,
  output logic          vs_out,
  output logic [PW-1:0] v_out,
  output logic          de_out,
  output logic [9:0]    pixel_x,
  output logic [9:0]    pixel_y,
  output logic          line_ovf
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int ZW = AW + 1;
  localparam logic [ZW-1:0] ZX_MAX   = {ZW{1'b1}};
  localparam logic [9:0]    COL_LAST = 10'(LINE_LEN - 1);
  localparam logic [7:0]    VS_LEN   = 8'(VS_THRESH);
  localparam logic [9:0]    HDE_S    = 10'(H_DE_START);
  localparam logic [9:0]    HDE_E    = 10'(H_DE_END);
  localparam logic [9:0]    VDE_S    = 10'(V_DE_START);
  localparam logic [9:0]    VDE_E    = 10'(V_DE_END);
  localparam logic [9:0]    HS_E     = 10'(HS_END);

  logic          csd_q, csd_d;
  logic [7:0]    sync_len_q, sync_len_d;
  logic          vs_q, vs_d;
  logic [9:0]    line_cnt_q, line_cnt_d;
  logic          sd_toggle_q, sd_toggle_d;
  logic          wr_half_q, wr_half_d;
  logic          rd_half_q, rd_half_d;
  logic          scanline_q, scanline_d;
  logic [9:0]    sd_col_q, sd_col_d;
  logic [ZW-1:0] zx_col_q, zx_col_d;
  logic          ovf_q, ovf_d;
  logic [9:0]    sd_d1_q, sd_d1_d;
  logic [9:0]    line_d1_q, line_d1_d;
  logic          hs_q, hs_d;
  logic          de_q, de_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [9:0]    px_q, px_d;

  logic          rise, eol, col_wrap, h_de, v_de, de, wr_en;
  logic [PW-1:0] pix;
  logic [AW:0]   wr_addr, rd_addr;

  logic [PW-1:0] line_buf [0:2*BUF_DEPTH-1];
  logic [PW-1:0] rd_data_q;

  assign wr_addr = {wr_half_q, zx_col_q[ZW-1:1]};
  assign rd_addr = {rd_half_q, AW'(sd_col_q)};

  // Buffer and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clkvga) begin
    if (wr_en) line_buf[wr_addr] <= v_in;
    if (ce_2pix) rd_data_q <= line_buf[rd_addr];
  end

  always_comb begin
    csd_d       = csd_q;
    sync_len_d  = sync_len_q;
    vs_d        = vs_q;
    line_cnt_d  = line_cnt_q;
    sd_toggle_d = sd_toggle_q;
    wr_half_d   = wr_half_q;
    rd_half_d   = rd_half_q;
    scanline_d  = scanline_q;
    sd_col_d    = sd_col_q;
    zx_col_d    = zx_col_q;
    ovf_d       = ovf_q;
    sd_d1_d     = sd_d1_q;
    line_d1_d   = line_d1_q;
    hs_d        = hs_q;
    de_d        = de_q;
    pix_d       = pix_q;
    px_d        = px_q;

    rise     = csync & ~csd_q;
    eol      = rise & (sync_len_q < VS_LEN);
    col_wrap = eol | (sd_col_q == COL_LAST);
    h_de     = (sd_d1_q >= HDE_S) && (sd_d1_q < HDE_E);
    v_de     = (line_d1_q >= VDE_S) && (line_d1_q < VDE_E);
    de       = h_de & v_de;
    wr_en    = ce_2pix & zx_col_q[0] & (zx_col_q != ZX_MAX);

    if (!de)
      pix = '0;
    else if (scanline_q && scan_mode == 2'b01)
      pix = '0;
    else if (scanline_q && scan_mode == 2'b10)
      pix = rd_data_q >> 1;
    else
      pix = rd_data_q;

    if (ce_2pix) begin
      csd_d = csync;
      if (csync) begin
        sync_len_d = '0;
        vs_d       = 1'b0;
      end else if (sync_len_q != 8'hFF) begin
        sync_len_d = sync_len_q + 8'd1;
      end

      if (rise) begin
        sd_toggle_d = ~sd_toggle_q;
        wr_half_d   = ~sd_toggle_q;
        rd_half_d   = sd_toggle_q;
        line_cnt_d  = line_cnt_q + 10'd1;
      end

      // eol and the natural column wrap can coincide; either restarts the line once.
      if (col_wrap) begin
        sd_col_d   = '0;
        scanline_d = ~scanline_q;
      end else begin
        sd_col_d = sd_col_q + 10'd1;
      end

      if (!csync && sync_len_q == VS_LEN) begin
        vs_d       = 1'b1;
        line_cnt_d = '0;
        scanline_d = 1'b0;
      end

      if (eol)
        zx_col_d = '0;
      else if (zx_col_q != ZX_MAX)
        zx_col_d = zx_col_q + ZW'(1);
      if (zx_col_q == ZX_MAX) ovf_d = 1'b1;

      sd_d1_d   = sd_col_q;
      line_d1_d = line_cnt_q;
      hs_d      = sd_d1_q < HS_E;
      de_d      = de;
      pix_d     = pix;
      px_d      = sd_d1_q;
    end
  end

  always_ff @(posedge clkvga or posedge rst) begin
    if (rst) begin
      csd_q       <= 1'b1;
      sync_len_q  <= '0;
      vs_q        <= 1'b0;
      line_cnt_q  <= '0;
      sd_toggle_q <= 1'b0;
      wr_half_q   <= 1'b0;
      rd_half_q   <= 1'b0;
      scanline_q  <= 1'b0;
      sd_col_q    <= '0;
      zx_col_q    <= '0;
      ovf_q       <= 1'b0;
      sd_d1_q     <= '0;
      line_d1_q   <= '0;
      hs_q        <= 1'b0;
      de_q        <= 1'b0;
      pix_q       <= '0;
      px_q        <= '0;
    end else begin
      csd_q       <= csd_d;
      sync_len_q  <= sync_len_d;
      vs_q        <= vs_d;
      line_cnt_q  <= line_cnt_d;
      sd_toggle_q <= sd_toggle_d;
      wr_half_q   <= wr_half_d;
      rd_half_q   <= rd_half_d;
      scanline_q  <= scanline_d;
      sd_col_q    <= sd_col_d;
      zx_col_q    <= zx_col_d;
      ovf_q       <= ovf_d;
      sd_d1_q     <= sd_d1_d;
      line_d1_q   <= line_d1_d;
      hs_q        <= hs_d;
      de_q        <= de_d;
      pix_q       <= pix_d;
      px_q        <= px_d;
    end
  end

  assign hs_out   = hs_q;
  assign vs_out   = vs_q;
  assign v_out    = pix_q;
  assign de_out   = de_q;
  assign pixel_x  = px_q;
  assign pixel_y  = line_cnt_q;
  assign line_ovf = ovf_q;

endmodule

// File: tb/tb_scandoubler_px.sv
// Bench for scandoubler_px: directed sync/line stimulus, expected outputs queued per ce
// and checked by a separate monitor process.
module tb_scandoubler_px;

  localparam int PW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       csync = 1'b1;
  logic [1:0] scan_mode = 2'b00;
  logic [2:0] v_in = 3'd0;
  logic       hs_out, vs_out, de_out, line_ovf;
  logic [2:0] v_out;
  logic [9:0] pixel_x, pixel_y;

  always #5 clk = ~clk;

  scandoubler_px #(
    .PW(PW), .LINE_LEN(40), .BUF_DEPTH(64), .VS_THRESH(10),
    .H_DE_START(4), .H_DE_END(16), .V_DE_START(3), .V_DE_END(10), .HS_END(34)
  ) dut (
    .clkvga(clk), .rst(rst), .ce_2pix(ce), .scan_mode(scan_mode), .csync(csync),
    .v_in(v_in), .hs_out(hs_out), .vs_out(vs_out), .v_out(v_out), .de_out(de_out),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .line_ovf(line_ovf)
  );

  typedef struct {
    int       kind;   // 0 video sample, 1 vsync/line count, 2 overflow flag
    int       due;
    int       px;
    int       py;
    bit       de;
    bit       hs;
    bit       vs;
    bit       ovf;
    logic [2:0] v;
    string    name;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   ce_n = 0;
  int   drv_n = 0;

  // Per input line L: scan mode, pixel value written, and value expected on the doubled line.
  int mode_tab [10] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 0};
  int val_tab  [10] = '{0, 6, 6, 6, 6, 5, 3, 7, 0, 0};
  int want_tab [10] = '{0, 0, 6, 6, 0, 6, 2, 3, 7, 0};
  int cols     [8]  = '{3, 4, 10, 15, 16, 33, 34, 37};

  task automatic record(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s %s", name, detail);
    end else begin
      $display("ok   %s %s", name, detail);
    end
  endtask

  task automatic push(input int kind, input int due, input int px, input int py, input bit de,
                      input bit hs, input bit vs, input bit ovf, input int v, input string name);
    exp_t e;
    e.kind = kind; e.due = due; e.px = px; e.py = py; e.de = de;
    e.hs = hs; e.vs = vs; e.ovf = ovf; e.v = 3'(v); e.name = name;
    sbq.push_back(e);
  endtask

  task automatic do_ce(input logic cs, input logic [2:0] v);
    @(negedge clk);
    csync = cs;
    v_in  = v;
    ce    = 1'b1;
    drv_n++;
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic run_line(input int n_hi, input int n_lo, input int v);
    for (int i = 0; i < n_hi; i++) do_ce(1'b1, 3'(v));
    for (int i = 0; i < n_lo; i++) do_ce(1'b0, 3'(v));
  endtask

  task automatic monitor_proc();
    exp_t  e;
    bit    ok;
    string got;
    forever begin
      @(posedge clk);
      if (ce && !rst) begin
        ce_n++;
        #1;
        while (sbq.size() > 0 && sbq[0].due <= ce_n) begin
          e   = sbq.pop_front();
          got = $sformatf("px=%0d py=%0d de=%0b hs=%0b vs=%0b v=%0d ovf=%0b",
                          pixel_x, pixel_y, de_out, hs_out, vs_out, v_out, line_ovf);
          if (e.due < ce_n) begin
            record(e.name, 1'b0, $sformatf("missed due=%0d now=%0d", e.due, ce_n));
          end else if (e.kind == 0) begin
            ok = (pixel_x === 10'(e.px)) && (pixel_y === 10'(e.py)) && (de_out === e.de) &&
                 (hs_out === e.hs) && (vs_out === 1'b0) && (v_out === e.v) && (line_ovf === e.ovf);
            record(e.name, ok, $sformatf("ce=%0d got %s want px=%0d py=%0d de=%0b hs=%0b vs=0 v=%0d ovf=%0b",
                                         ce_n, got, e.px, e.py, e.de, e.hs, e.v, e.ovf));
          end else if (e.kind == 1) begin
            ok = (vs_out === e.vs) && (pixel_y === 10'(e.py));
            record(e.name, ok, $sformatf("ce=%0d got vs=%0b py=%0d want vs=%0b py=%0d",
                                         ce_n, vs_out, pixel_y, e.vs, e.py));
          end else begin
            ok = (line_ovf === e.ovf);
            record(e.name, ok, $sformatf("ce=%0d got ovf=%0b want ovf=%0b", ce_n, line_ovf, e.ovf));
          end
        end
      end
    end
  endtask

  task automatic driver_proc();
    int  r;
    int  k;
    bit  act;
    exp_t e;
    repeat (3) @(negedge clk);
    record("rst_outputs", {hs_out, vs_out, de_out, line_ovf, v_out, pixel_x, pixel_y} === '0,
           $sformatf("got hs=%0b vs=%0b de=%0b ovf=%0b v=%0d px=%0d py=%0d want all 0",
                     hs_out, vs_out, de_out, line_ovf, v_out, pixel_x, pixel_y));
    @(negedge clk);
    rst = 1'b0;

    // vsync: 12 low ce then high
    push(1, 10, 0, 0, 0, 0, 0, 0, 0, "vs_before_thresh");
    push(1, 11, 0, 0, 0, 0, 1, 0, 0, "vs_rise");
    push(1, 12, 0, 0, 0, 0, 1, 0, 0, "vs_hold");
    push(1, 13, 0, 1, 0, 0, 0, 0, 0, "vs_fall");
    run_line(0, 12, 0);
    run_line(24, 4, 0);

    for (int L = 1; L <= 9; L++) begin
      r = drv_n + 1;
      scan_mode = 2'(mode_tab[L]);
      act = (L + 1 >= 3) && (L + 1 < 10);
      for (int c = 0; c < 8; c++) begin
        k = cols[c];
        push(0, r + k + 2, k, L + 1, act && k >= 4 && k < 16, k < 34, 0, 0,
             (act && k >= 4 && k < 16) ? want_tab[L] : 0, $sformatf("L%0d_px%0d", L, k));
      end
      run_line(36, 4, val_tab[L]);
    end

    // over-long input line drives zx_col into saturation
    r = drv_n + 1;
    push(2, r + 100, 0, 0, 0, 0, 0, 0, 0, "ovf_clear_mid");
    push(2, r + 127, 0, 0, 0, 0, 0, 0, 0, "ovf_clear_edge");
    push(2, r + 128, 0, 0, 0, 0, 0, 1, 0, "ovf_set");
    run_line(140, 4, 5);
    r = drv_n + 1;
    push(2, r + 20, 0, 0, 0, 0, 0, 1, 0, "ovf_sticky");
    run_line(36, 4, 0);
    run_line(3, 0, 0);

    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      record(e.name, 1'b0, $sformatf("never reached due=%0d now=%0d", e.due, ce_n));
    end

    // asynchronous reset between clock edges
    @(negedge clk);
    record("ovf_before_rst", line_ovf === 1'b1, $sformatf("got ovf=%0b want 1", line_ovf));
    #2 rst = 1'b1;
    #1;
    record("arst_ovf", line_ovf === 1'b0, $sformatf("got ovf=%0b want 0", line_ovf));
    record("arst_py", pixel_y === 10'd0, $sformatf("got py=%0d want 0", pixel_y));
    record("arst_hs", hs_out === 1'b0, $sformatf("got hs=%0b want 0", hs_out));
    record("arst_px", pixel_x === 10'd0, $sformatf("got px=%0d want 0", pixel_x));
    record("arst_v_de", {v_out, de_out, vs_out} === 5'd0,
           $sformatf("got v=%0d de=%0b vs=%0b want 0 0 0", v_out, de_out, vs_out));
    @(negedge clk);
    rst = 1'b0;
    run_line(10, 0, 0);
    record("post_rst_py", pixel_y === 10'd0, $sformatf("got py=%0d want 0", pixel_y));
    record("post_rst_px", pixel_x === 10'd8, $sformatf("got px=%0d want 8", pixel_x));
    record("post_rst_hs_de", {hs_out, de_out, vs_out} === 3'b100,
           $sformatf("got hs=%0b de=%0b vs=%0b want 1 0 0", hs_out, de_out, vs_out));
    record("post_rst_ovf", line_ovf === 1'b0, $sformatf("got ovf=%0b want 0", line_ovf));
  endtask

  initial begin
    fork
      driver_proc();
      monitor_proc();
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
